// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: state encoding and default geometry, common to the SPI endpoints.
package spi_slave_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;
    assign fall = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled pins, byte deserialiser on mosi, buffered byte serialiser on miso.
// Optional sticky underrun/abort status when SPI_SLAVE_STATUS_EN is defined.
//
// state      | meaning
// SPI_IDLE   | cs high, miso held 0, waiting for synced cs falling edge
// SPI_ACTIVE | frame in progress, shifting on synced sck edges until cs rises
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic              status_clr,
    output logic [1:0]        status
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] FILL     = {DATA_W{1'b1}};

    spi_state_t             state;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift, tx_shift_next, tx_buf, reload_val;
    logic                   frame_start, frame_end, word_reload, tx_accept;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi gets the same depth as sck so the sampled bit lines up with the detected edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_comb begin
        frame_start   = (state == SPI_IDLE) && cs_fall;
        frame_end     = (state == SPI_ACTIVE) && cs_rise;
        word_reload   = (state == SPI_ACTIVE) && !cs_rise && sck_fall && (bit_cnt == '0);
        reload_val    = tx_ready ? FILL : tx_buf;
        tx_accept     = tx_load && tx_ready;
        tx_shift_next = tx_shift;
        if (frame_start || word_reload)
            tx_shift_next = reload_val;
        else if ((state == SPI_ACTIVE) && !cs_rise && sck_fall)
            tx_shift_next = {tx_shift[DATA_W-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SPI_IDLE;
            busy     <= 1'b0;
            miso     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_shift <= FILL;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            tx_shift <= tx_shift_next;
            // a load coinciding with a reload wins: the reload already took the old contents
            if (tx_accept) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (frame_start || word_reload) begin
                tx_ready <= 1'b1;
            end
            case (state)
                SPI_IDLE: begin
                    if (cs_fall) begin
                        state   <= SPI_ACTIVE;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        miso    <= tx_shift_next[DATA_W-1];
                    end
                end
                SPI_ACTIVE: begin
                    if (frame_end) begin
                        state   <= SPI_IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        miso    <= 1'b0;
                    end else begin
                        miso <= tx_shift_next[DATA_W-1];
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {rx_shift, mosi_s};
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic [1:0] status_q;
    logic [1:0] status_set;

    always_comb begin
        status_set[0] = (frame_start || word_reload) && tx_ready;
        status_set[1] = frame_end && (bit_cnt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= 2'b00;
        else     status_q <= (status_clr ? 2'b00 : status_q) | status_set;
    end
    assign status = status_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Randomised self-checking bench for spi_slave against a word-level buffer/frame model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, sck, cs, mosi, miso, tx_load, tx_ready, rx_valid, busy;
    logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clr;
    logic [1:0] status;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    logic [7:0] rx_q[$];
    int         lat_q[$];

    // word-level model: one-deep tx buffer plus sticky event flags
    logic [7:0] m_buf = 8'h00;
    bit         m_empty = 1'b1;
    logic [1:0] m_status = 2'b00;

    spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
`ifdef SPI_SLAVE_STATUS_EN
        ,
        .status_clr (status_clr),
        .status     (status)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            lat_q.push_back(cyc - last_rise);
        end
    end

    task automatic model_pop(output logic [7:0] v);
        if (m_empty) begin
            v = 8'hFF;
            m_status[0] = 1'b1;
        end else begin
            v = m_buf;
        end
        m_empty = 1'b1;
    endtask

    task automatic do_load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (m_empty) begin
            m_buf   = v;
            m_empty = 1'b0;
        end
        checks++;
        if (tx_ready !== m_empty) begin
            errors++;
            $display("FAIL tx_ready_after_load: got %b expected %b", tx_ready, m_empty);
        end
    endtask

    task automatic clear_status();
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
`endif
        m_status = 2'b00;
    endtask

    // Master side of one frame: sck period 8 clk, miso sampled just before each rising edge.
    // nbits > 0 aborts the frame after that many bits.
    task automatic spi_frame(input int nw, input int nbits, input logic [7:0] mo[0:2],
                             input int load_word, input logic [7:0] load_val,
                             output logic [7:0] mi[0:2], output logic [7:0] ex[0:2]);
        int total;
        logic [7:0] t;
        total = (nbits > 0) ? nbits : nw * 8;
        rx_q.delete();
        lat_q.delete();
        for (int k = 0; k < 3; k++) begin
            mi[k] = 8'h00;
            ex[k] = 8'h00;
        end
        cs = 1'b0;
        model_pop(ex[0]);
        for (int i = 0; i < total; i++) begin
            int w;
            int b;
            w = i / 8;
            b = 7 - (i % 8);
            mosi = mo[w][b];
            if (w == load_word && (i % 8) == 4) begin
                repeat (3) @(negedge clk);
                do_load(load_val);
            end else begin
                repeat (4) @(negedge clk);
            end
            mi[w][b] = miso;
            sck = 1'b1;
            last_rise = cyc;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if ((i % 8) == 7) begin
                model_pop(t);
                if (w + 1 < 3) ex[w+1] = t;
            end
        end
        if ((total % 8) != 0) m_status[1] = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        logic [7:0] bits_exp[8];
        bits_exp = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
        do_load(8'h4D);
        mo = '{8'h4C, 8'h00, 8'h00};
        spi_frame(1, 0, mo, -1, 8'h00, mi, ex);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({7'b0, mi[0][7-k]} !== bits_exp[k]) begin
                errors++;
                $display("FAIL basic_miso_bit%0d: got %b expected %0d", k, mi[0][7-k], bits_exp[k]);
            end
        end
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("FAIL basic_rx_pulses: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'h4C) begin
                errors++;
                $display("FAIL basic_rx_data: got %h expected 4c", rx_q[0]);
            end
            checks++;
            if (lat_q[0] != 3) begin
                errors++;
                $display("FAIL basic_rx_latency: got %0d expected 3", lat_q[0]);
            end
        end
        checks++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after_cs: busy %b miso %b expected 0 0", busy, miso);
        end
    endtask

    task automatic test_reset();
        do_load(8'h77);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_before: got %b expected 1", busy);
        end
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        cs  = 1'b1;
        sck = 1'b0;
        #1;
        checks++;
        if (miso !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || busy !== 1'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: miso %b tx_ready %b rx_valid %b busy %b rx_data %h expected 0 1 0 0 00",
                     miso, tx_ready, rx_valid, busy, rx_data);
        end
`ifdef SPI_SLAVE_STATUS_EN
        checks++;
        if (status !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00", status);
        end
`endif
        m_empty  = 1'b1;
        m_status = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_two_word();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        logic [7:0] first;
        first = 8'($urandom);
        do_load(first);
        mo = '{8'h12, 8'h34, 8'h00};
        spi_frame(2, 0, mo, 0, 8'hA5, mi, ex);
        checks++;
        if (mi[0] !== first) begin
            errors++;
            $display("FAIL two_word_miso0: got %h expected %h", mi[0], first);
        end
        checks++;
        if (mi[1] !== 8'hA5) begin
            errors++;
            $display("FAIL two_word_miso1: got %h expected a5", mi[1]);
        end
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("FAIL two_word_rx_pulses: got %0d expected 2", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
                errors++;
                $display("FAIL two_word_rx_data: got %h %h expected 12 34", rx_q[0], rx_q[1]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        clear_status();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL underrun_tx_ready: got %b expected 1", tx_ready);
        end
        mo = '{8'($urandom), 8'h00, 8'h00};
        spi_frame(1, 0, mo, -1, 8'h00, mi, ex);
        checks++;
        if (mi[0] !== 8'hFF) begin
            errors++;
            $display("FAIL underrun_miso: got %h expected ff", mi[0]);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== mo[0]) begin
            errors++;
            $display("FAIL underrun_rx: got %0d words expected 1 word %h", rx_q.size(), mo[0]);
        end
`ifdef SPI_SLAVE_STATUS_EN
        checks++;
        if (status !== 2'b01) begin
            errors++;
            $display("FAIL underrun_status: got %b expected 01", status);
        end
        clear_status();
        checks++;
        if (status !== 2'b00) begin
            errors++;
            $display("FAIL underrun_status_clr: got %b expected 00", status);
        end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        clear_status();
        mo = '{8'($urandom), 8'h00, 8'h00};
        spi_frame(1, 5, mo, -1, 8'h00, mi, ex);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rx_pulses: got %0d expected 0", rx_q.size());
        end
        checks++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b miso %b expected 0 0", busy, miso);
        end
`ifdef SPI_SLAVE_STATUS_EN
        checks++;
        if (status[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_status: got %b expected 1", status[1]);
        end
`endif
        mo = '{8'h3C, 8'h00, 8'h00};
        spi_frame(1, 0, mo, -1, 8'h00, mi, ex);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            errors++;
            $display("FAIL abort_realign: got %0d words first %h expected 1 word 3c",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        do_load(8'h11);
        do_load(8'h22);
        mo = '{8'($urandom), 8'h00, 8'h00};
        spi_frame(1, 0, mo, -1, 8'h00, mi, ex);
        checks++;
        if (mi[0] !== 8'h11) begin
            errors++;
            $display("FAIL ignored_load_miso: got %h expected 11", mi[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] mo[0:2], mi[0:2], ex[0:2];
        int nw, lw;
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) mo[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            if ($urandom_range(0, 2) == 0) do_load(8'($urandom));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            lw = $urandom_range(0, nw);
            spi_frame(nw, 0, mo, lw, 8'($urandom), mi, ex);
            for (int k = 0; k < nw; k++) begin
                checks++;
                if (mi[k] !== ex[k]) begin
                    errors++;
                    $display("FAIL random_miso it%0d w%0d: got %h expected %h", it, k, mi[k], ex[k]);
                end
            end
            checks++;
            if (rx_q.size() != nw) begin
                errors++;
                $display("FAIL random_rx_pulses it%0d: got %0d expected %0d", it, rx_q.size(), nw);
            end else begin
                for (int k = 0; k < nw; k++) begin
                    checks++;
                    if (rx_q[k] !== mo[k] || lat_q[k] != 3) begin
                        errors++;
                        $display("FAIL random_rx it%0d w%0d: got %h lat %0d expected %h lat 3",
                                 it, k, rx_q[k], lat_q[k], mo[k]);
                    end
                end
            end
`ifdef SPI_SLAVE_STATUS_EN
            checks++;
            if (status !== m_status) begin
                errors++;
                $display("FAIL random_status it%0d: got %b expected %b", it, status, m_status);
            end
`endif
        end
    endtask

    initial begin
        rst     = 1'b1;
        sck     = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b0;
        tx_load = 1'b0;
        tx_data = 8'h00;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        test_basic();
        test_reset();
        test_two_word();
        test_underrun();
        test_abort();
        test_ignored_load();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
